// File: rtl/alu_req_sequencer.sv
// Round-robin sequencer sharing one combinational ALU between two requesters.
// Optional macro ALU_OVF_TRAP_EN: ADD/SUB overflow zeroes the data and sets a sticky ovf_trap.
module alu_req_sequencer #(
  parameter int DW         = 16,
  parameter int CW         = 4,
  parameter int MUL_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic          req1_valid,
  output logic          req0_ready,
  output logic          req1_ready,
  input  logic [CW-1:0] req0_op,
  input  logic [CW-1:0] req1_op,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req0_b,
  input  logic [DW-1:0] req1_b,
  output logic [DW-1:0] alu_src1,
  output logic [DW-1:0] alu_src2,
  output logic [CW-1:0] alu_ctrl,
  input  logic [DW:0]   alu_result,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_zero,
  output logic          rsp_ovf,
  output logic          rsp_illegal,
  output logic          ovf_trap
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [CW-1:0] OP_AND = 4'b0000;
  localparam logic [CW-1:0] OP_OR  = 4'b0001;
  localparam logic [CW-1:0] OP_ADD = 4'b0010;
  localparam logic [CW-1:0] OP_SUB = 4'b0110;
  localparam logic [CW-1:0] OP_SLT = 4'b0111;
  localparam logic [CW-1:0] OP_MUL = 4'b1000;
  localparam logic [CW-1:0] OP_NOR = 4'b1100;

  state_t        state_q;
  logic          rr_q;
  logic          id_q;
  logic [CW-1:0] op_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [3:0]    cnt_q;
  logic          rsp_valid_q;
  logic [DW-1:0] rsp_data_q;
  logic          rsp_zero_q;
  logic          rsp_ovf_q;
  logic          rsp_illegal_q;

  logic          grant_d;
  logic          accept_d;
  logic          op_legal_d;
  logic          mul_wait_d;
  logic          capture_d;
  logic          cap_ovf_d;
  logic [DW-1:0] cap_data_d;

  // On a tie rr_q picks the winner; otherwise whoever is valid wins.
  assign grant_d    = (req0_valid && req1_valid) ? rr_q : req1_valid;
  assign accept_d   = (state_q == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept_d && req0_valid && !grant_d;
  assign req1_ready = accept_d && req1_valid && grant_d;

  assign op_legal_d = (op_q == OP_AND) || (op_q == OP_OR)  || (op_q == OP_ADD) ||
                      (op_q == OP_SUB) || (op_q == OP_SLT) || (op_q == OP_MUL) ||
                      (op_q == OP_NOR);
  assign mul_wait_d = (op_q == OP_MUL) && (MUL_CYCLES > 1);
  assign capture_d  = ((state_q == ISSUE) && op_legal_d && !mul_wait_d) ||
                      ((state_q == WAIT) && (cnt_q == 4'd1));

  always_comb begin
    cap_ovf_d  = ((op_q == OP_ADD) || (op_q == OP_SUB)) && alu_result[DW];
    cap_data_d = alu_result[DW-1:0];
`ifdef ALU_OVF_TRAP_EN
    if (cap_ovf_d) cap_data_d = '0;
`endif
  end

  // Operand registers only change on accept, so the ALU inputs are quiet when idle.
  assign alu_src1    = a_q;
  assign alu_src2    = b_q;
  assign alu_ctrl    = op_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = id_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_zero    = rsp_zero_q;
  assign rsp_ovf     = rsp_ovf_q;
  assign rsp_illegal = rsp_illegal_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_q          <= 1'b0;
      id_q          <= 1'b0;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      cnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_ovf_q     <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            id_q    <= grant_d;
            op_q    <= grant_d ? req1_op : req0_op;
            a_q     <= grant_d ? req1_a  : req0_a;
            b_q     <= grant_d ? req1_b  : req0_b;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (!op_legal_d) begin
            rsp_data_q    <= '0;
            rsp_zero_q    <= 1'b1;
            rsp_ovf_q     <= 1'b0;
            rsp_illegal_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            state_q       <= RESP;
          end else if (mul_wait_d) begin
            cnt_q   <= 4'(MUL_CYCLES - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != 4'd1) cnt_q <= cnt_q - 4'd1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rr_q        <= ~id_q;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (capture_d) begin
        rsp_data_q    <= cap_data_d;
        rsp_zero_q    <= (cap_data_d == '0);
        rsp_ovf_q     <= cap_ovf_d;
        rsp_illegal_q <= 1'b0;
        rsp_valid_q   <= 1'b1;
        state_q       <= RESP;
      end
    end
  end

`ifdef ALU_OVF_TRAP_EN
  logic trap_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) trap_q <= 1'b0;
    else if (capture_d && cap_ovf_d) trap_q <= 1'b1;
  end
  assign ovf_trap = trap_q;
`else
  assign ovf_trap = 1'b0;
`endif

endmodule

// File: tb/tb_alu_req_sequencer.sv
// Scoreboard bench for alu_req_sequencer with a behavioural ALU attached to its ALU port.
module tb_alu_req_sequencer;
  localparam int MC = 3;

  logic        clk, rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [15:0] req0_a, req1_a, req0_b, req1_b;
  logic [15:0] alu_src1, alu_src2;
  logic [3:0]  alu_ctrl;
  logic [16:0] alu_result;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_ovf, rsp_illegal, ovf_trap;
  logic [15:0] rsp_data;

`ifdef ALU_OVF_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef struct {
    logic        id;
    logic [15:0] data;
    logic        zero;
    logic        ovf;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic exp_trap = 1'b0;

  alu_req_sequencer #(.DW(16), .CW(4), .MUL_CYCLES(MC)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf),
    .rsp_illegal(rsp_illegal), .ovf_trap(ovf_trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU; undefined op codes return garbage so a DUT that uses them is caught.
  function automatic logic [16:0] alu_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic        v;
    r = '0;
    v = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
      4'b0110: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
      4'b0111: r = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      4'b1000: r = a * b;
      4'b1100: r = ~(a | b);
      default: begin r = 16'hDEAD; v = 1'b1; end
    endcase
    return {v, r};
  endfunction

  assign alu_result = alu_model(alu_ctrl, alu_src1, alu_src2);

  function automatic exp_t make_exp(input logic id, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    logic [16:0] r;
    e.id = id;
    if (!(op inside {4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h8, 4'hC})) begin
      e.data = '0; e.ovf = 1'b0; e.ill = 1'b1;
    end else begin
      r      = alu_model(op, a, b);
      e.ill  = 1'b0;
      e.ovf  = ((op == 4'h2) || (op == 4'h6)) && r[16];
      e.data = (TRAP_EN && e.ovf) ? 16'h0000 : r[15:0];
    end
    e.zero = (e.data == 16'h0000);
    return e;
  endfunction

  task automatic drive(input logic id, input logic v, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    if (id) begin req1_valid = v; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = v; req0_op = op; req0_a = a; req0_b = b; end
  endtask

  // Entered at the negedge after the accept edge t; leaves at the negedge after the handshake.
  task automatic wait_and_check(input int t, input int exp_lat, input logic [3:0] op,
                                input logic [15:0] a, input logic [15:0] b, input string name);
    exp_t e;
    while (!rsp_valid && (cyc - t) < 20) begin
      checks++;
      if ({alu_ctrl, alu_src1, alu_src2} !== {op, a, b}) begin
        errors++;
        $display("FAIL %s alu_hold: got ctrl=%h src1=%h src2=%h, want ctrl=%h src1=%h src2=%h",
                 name, alu_ctrl, alu_src1, alu_src2, op, a, b);
      end
      @(negedge clk);
    end
    checks++;
    if ((cyc - t) !== exp_lat || !rsp_valid) begin
      errors++;
      $display("FAIL %s latency: got %0d (rsp_valid=%b), want %0d", name, cyc - t, rsp_valid, exp_lat);
    end
    if (!rsp_valid || sb.size() == 0) return;
    e = sb.pop_front();
    if (TRAP_EN && e.ovf) exp_trap = 1'b1;
    checks++;
    if ({rsp_id, rsp_data, rsp_zero, rsp_ovf, rsp_illegal} !== {e.id, e.data, e.zero, e.ovf, e.ill}) begin
      errors++;
      $display("FAIL %s rsp: got id=%b data=%h zero=%b ovf=%b ill=%b, want id=%b data=%h zero=%b ovf=%b ill=%b",
               name, rsp_id, rsp_data, rsp_zero, rsp_ovf, rsp_illegal, e.id, e.data, e.zero, e.ovf, e.ill);
    end
    checks++;
    if (ovf_trap !== exp_trap) begin
      errors++;
      $display("FAIL %s ovf_trap: got %b, want %b", name, ovf_trap, exp_trap);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s one_cycle_rsp: rsp_valid got %b, want 0", name, rsp_valid);
    end
  endtask

  task automatic run_txn(input logic id, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input int exp_lat, input string name);
    int t;
    int w;
    rsp_ready = 1'b1;
    drive(id, 1'b1, op, a, b);
    #1;
    w = 0;
    while (!(id ? req1_ready : req0_ready) && w < 10) begin @(negedge clk); w++; end
    checks++;
    if (w != 0) begin
      errors++;
      $display("FAIL %s accept: waited %0d cycles, want 0", name, w);
      if (!(id ? req1_ready : req0_ready)) begin drive(id, 1'b0, op, a, b); return; end
    end
    t = cyc;
    sb.push_back(make_exp(id, op, a, b));
    @(negedge clk);
    drive(id, 1'b0, 4'h0, 16'h0, 16'h0);
    wait_and_check(t, exp_lat, op, a, b, name);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({alu_src1, alu_src2, alu_ctrl, rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_ovf, rsp_illegal,
         ovf_trap, req0_ready, req1_ready} !== '0) begin
      errors++;
      $display("FAIL reset_values: got src1=%h src2=%h ctrl=%h rv=%b id=%b data=%h z=%b o=%b i=%b trap=%b, want all 0",
               alu_src1, alu_src2, alu_ctrl, rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_ovf, rsp_illegal, ovf_trap);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_round_robin;
    logic [15:0] a0, a1;
    logic        g;
    int          t;
    int          w;
    a0 = 16'h00F0;
    a1 = 16'h1000;
    rsp_ready = 1'b1;
    drive(1'b0, 1'b1, 4'h0, a0, 16'h0FF0);
    drive(1'b1, 1'b1, 4'h1, a1, 16'h0003);
    #1;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (!(req0_ready || req1_ready) && w < 10) begin @(negedge clk); w++; end
      g = req1_ready;
      checks++;
      if ((req0_ready && req1_ready) || !(req0_ready || req1_ready) || g !== k[0]) begin
        errors++;
        $display("FAIL rr_grant%0d: got ready0=%b ready1=%b, want winner %0d", k, req0_ready, req1_ready, k % 2);
        break;
      end
      t = cyc;
      if (g) sb.push_back(make_exp(1'b1, 4'h1, a1, 16'h0003));
      else   sb.push_back(make_exp(1'b0, 4'h0, a0, 16'h0FF0));
      @(negedge clk);
      if (g) begin
        wait_and_check(t, 2, 4'h1, a1, 16'h0003, "rr");
        a1 = a1 + 16'h0011;
        drive(1'b1, 1'b1, 4'h1, a1, 16'h0003);
      end else begin
        wait_and_check(t, 2, 4'h0, a0, 16'h0FF0, "rr");
        a0 = a0 + 16'h0101;
        drive(1'b0, 1'b1, 4'h0, a0, 16'h0FF0);
      end
      #1;
    end
    drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 4'h0, 16'h0, 16'h0);
    @(negedge clk);
  endtask

  task automatic test_dropped_request;
    int t;
    rsp_ready = 1'b1;
    drive(1'b0, 1'b1, 4'h7, 16'hFFFF, 16'h0001);
    #1;
    t = cyc;
    sb.push_back(make_exp(1'b0, 4'h7, 16'hFFFF, 16'h0001));
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
    drive(1'b1, 1'b1, 4'h0, 16'hAAAA, 16'h5555);
    #1;
    checks++;
    if (req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_ready: req1_ready got %b, want 0", req1_ready);
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 4'h0, 16'h0, 16'h0);
    wait_and_check(t, 2, 4'h7, 16'hFFFF, 16'h0001, "slt_drop");
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL dropped_req: rsp_valid got %b, want 0", rsp_valid);
      end
    end
  endtask

  task automatic test_reset_mid_resp;
    int t;
    rsp_ready = 1'b0;
    drive(1'b0, 1'b1, 4'h2, 16'h0100, 16'h0023);
    #1;
    t = cyc;
    sb.push_back(make_exp(1'b0, 4'h2, 16'h0100, 16'h0023));
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
    @(negedge clk);
    repeat (5) begin
      checks++;
      if ({rsp_valid, rsp_data} !== {1'b1, 16'h0123}) begin
        errors++;
        $display("FAIL hold_rsp: got valid=%b data=%h at +%0d, want valid=1 data=0123", rsp_valid, rsp_data, cyc - t);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    sb.delete();
    exp_trap = 1'b0;
    checks++;
    if ({alu_src1, alu_src2, alu_ctrl, rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_ovf, rsp_illegal, ovf_trap} !== '0) begin
      errors++;
      $display("FAIL async_reset: got src1=%h ctrl=%h rv=%b data=%h trap=%b, want all 0",
               alu_src1, alu_ctrl, rsp_valid, rsp_data, ovf_trap);
    end
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL no_rsp_after_reset: rsp_valid got %b, want 0", rsp_valid);
      end
    end
    run_txn(1'b1, 4'h2, 16'h0010, 16'h0020, 2, "add_after_reset");
  endtask

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 4'h0, 16'h0, 16'h0);
    @(negedge clk);
    test_reset();
    test_round_robin();
    run_txn(1'b0, 4'h2, 16'h0003, 16'h0004, 2, "add");
    run_txn(1'b1, 4'h8, 16'h0010, 16'h0020, MC + 1, "mul");
    run_txn(1'b0, 4'h6, 16'h0005, 16'h0005, 2, "sub_zero");
    run_txn(1'b1, 4'hF, 16'h1234, 16'h5678, 2, "illegal");
    test_dropped_request();
    run_txn(1'b0, 4'h2, 16'h7FFF, 16'h0001, 2, "add_ovf");
    run_txn(1'b1, 4'h1, 16'h0001, 16'h0002, 2, "or_after_ovf");
    run_txn(1'b0, 4'hC, 16'h00FF, 16'hF000, 2, "b2b_nor");
    run_txn(1'b1, 4'h0, 16'hFFFF, 16'h1234, 2, "b2b_and");
    run_txn(1'b0, 4'h8, 16'h0003, 16'h0007, MC + 1, "b2b_mul");
    test_reset_mid_resp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
